// File: rtl/snake_mover_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | snake_mover_pkg : direction/state codes and helpers for the snake  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package snake_mover_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  localparam logic [0:0] ST_ALIVE = 1'b0;
  localparam logic [0:0] ST_DEAD  = 1'b1;

  // Opposite directions differ only in the upper code bit.
  function automatic dir_e opposite(input dir_e d);
    return dir_e'(d ^ 2'd2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/snake_mover_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | snake_mover_if : control, query and status bundle of the snake     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface snake_mover_if #(
  parameter int COORD_W = 5,
  parameter int LEN_W   = 5
);
  logic               step;
  logic [1:0]         dir_req;
  logic               dir_valid;
  logic               grow;
  logic [COORD_W-1:0] qry_x;
  logic [COORD_W-1:0] qry_y;
  logic               qry_hit;
  logic [COORD_W-1:0] head_x;
  logic [COORD_W-1:0] head_y;
  logic [LEN_W-1:0]   length;
  logic               dead;

  modport master (
    output step, dir_req, dir_valid, grow, qry_x, qry_y,
    input  qry_hit, head_x, head_y, length, dead
  );

  modport slave (
    input  step, dir_req, dir_valid, grow, qry_x, qry_y,
    output qry_hit, head_x, head_y, length, dead
  );
endinterface
`default_nettype wire

// File: rtl/snake_mover_next_pos.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | snake_mover_next_pos : one-cell stepper with wrap-around grid      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module snake_mover_next_pos
  import snake_mover_pkg::*;
#(
  parameter int GRID_W  = 32,
  parameter int GRID_H  = 24,
  parameter int COORD_W = 5
) (
  input  wire logic [COORD_W-1:0] i_cur_x,
  input  wire logic [COORD_W-1:0] i_cur_y,
  input  wire dir_e               i_dir,
  output logic      [COORD_W-1:0] o_nxt_x,
  output logic      [COORD_W-1:0] o_nxt_y
);
  localparam logic [COORD_W-1:0] c_X_MAX = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] c_Y_MAX = COORD_W'(GRID_H - 1);

  always_comb begin
    o_nxt_x = i_cur_x;
    o_nxt_y = i_cur_y;
    case (i_dir)
      DIR_UP:    o_nxt_y = (i_cur_y == '0)      ? c_Y_MAX : i_cur_y - 1'b1;
      DIR_RIGHT: o_nxt_x = (i_cur_x == c_X_MAX) ? '0      : i_cur_x + 1'b1;
      DIR_DOWN:  o_nxt_y = (i_cur_y == c_Y_MAX) ? '0      : i_cur_y + 1'b1;
      DIR_LEFT:  o_nxt_x = (i_cur_x == '0)      ? c_X_MAX : i_cur_x - 1'b1;
      default:   ;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/snake_mover.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | snake_mover : snake head/body/length engine with death detection   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module snake_mover
  import snake_mover_pkg::*;
#(
  parameter int GRID_W  = 32,
  parameter int GRID_H  = 24,
  parameter int COORD_W = 5,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int START_X = 16,
  parameter int START_Y = 12
) (
  input wire logic     clock,
  input wire logic     reset,
  snake_mover_if.slave bus
);
  localparam logic [LEN_W-1:0]   c_MAX_LEN = LEN_W'(MAX_LEN);
  localparam logic [COORD_W-1:0] c_START_X = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] c_START_Y = COORD_W'(START_Y);

  logic [COORD_W-1:0] r_ex [MAX_LEN];
  logic [COORD_W-1:0] r_ey [MAX_LEN];
  logic [LEN_W-1:0]   r_len;
  dir_e               r_cur_dir;
  dir_e               r_next_dir;
  logic               r_pend_grow;
  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic               w_alive;

  logic               w_dir_ok;
  dir_e               w_dir;
  logic               w_growing;
  logic [LEN_W-1:0]   w_chk_len;
  logic [COORD_W-1:0] w_nxt_x;
  logic [COORD_W-1:0] w_nxt_y;
  logic [MAX_LEN-1:0] w_body_hit;
  logic [MAX_LEN-1:0] w_qry_vec;
  logic               w_collide;

  // Reversal is judged against the direction actually travelled, not the pending one.
  assign w_dir_ok  = bus.dir_valid && (bus.dir_req != opposite(r_cur_dir));
  assign w_dir     = w_dir_ok ? dir_e'(bus.dir_req) : r_next_dir;
  assign w_growing = (r_pend_grow || bus.grow) && (r_len < c_MAX_LEN);
  assign w_chk_len = w_growing ? r_len : r_len - 1'b1;

  snake_mover_next_pos #(
    .GRID_W  (GRID_W),
    .GRID_H  (GRID_H),
    .COORD_W (COORD_W)
  ) u_next_pos (
    .i_cur_x (r_ex[0]),
    .i_cur_y (r_ey[0]),
    .i_dir   (w_dir),
    .o_nxt_x (w_nxt_x),
    .o_nxt_y (w_nxt_y)
  );

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_cmp
    assign w_body_hit[i] = (LEN_W'(i) < w_chk_len) &&
                           (r_ex[i] == w_nxt_x) && (r_ey[i] == w_nxt_y);
    assign w_qry_vec[i]  = (LEN_W'(i) < r_len) &&
                           (r_ex[i] == bus.qry_x) && (r_ey[i] == bus.qry_y);
  end

  assign w_collide   = |w_body_hit;
  assign bus.qry_hit = |w_qry_vec;
  assign bus.head_x  = r_ex[0];
  assign bus.head_y  = r_ey[0];
  assign bus.length  = r_len;

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_ALIVE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ALIVE: if (bus.step && w_collide) w_state_nxt = ST_DEAD;
      ST_DEAD:  w_state_nxt = ST_DEAD;
    endcase
  end

  always_comb begin
    w_alive  = (r_state == ST_ALIVE);
    bus.dead = (r_state == ST_DEAD);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_ex[i] <= c_START_X;
        r_ey[i] <= c_START_Y;
      end
      r_len       <= LEN_W'(1);
      r_cur_dir   <= DIR_RIGHT;
      r_next_dir  <= DIR_RIGHT;
      r_pend_grow <= 1'b0;
    end else if (w_alive) begin
      if (bus.step) begin
        if (!w_collide) begin
          for (int i = MAX_LEN - 1; i > 0; i--) begin
            r_ex[i] <= r_ex[i-1];
            r_ey[i] <= r_ey[i-1];
          end
          r_ex[0]     <= w_nxt_x;
          r_ey[0]     <= w_nxt_y;
          r_len       <= r_len + {{(LEN_W-1){1'b0}}, w_growing};
          r_cur_dir   <= w_dir;
          r_next_dir  <= w_dir;
          r_pend_grow <= 1'b0;
        end
      end else begin
        r_next_dir <= w_dir;
        if (bus.grow) r_pend_grow <= 1'b1;
      end
    end
  end
endmodule
`default_nettype wire
